// File: rtl/mem_pkg.sv
// mem_pkg: shared types, widths and fault classification for mem_responder.
// Imported by the interface, the storage array, the top level and the bench.
package mem_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE,
        FAULT_ODD,
        FAULT_RW,
        FAULT_RO
    } fault_e;

    // Priority order: odd address first, then read+write together, then
    // a write into the protected low region (only when ro_en is set).
    function automatic fault_e classify_fault(
        input logic odd,
        input logic rd,
        input logic wr,
        input logic below_ro,
        input logic ro_en
    );
        fault_e reason;
        reason = FAULT_NONE;
        if (odd) begin
            reason = FAULT_ODD;
        end else if (rd && wr) begin
            reason = FAULT_RW;
        end else if (wr && below_ro && ro_en) begin
            reason = FAULT_RO;
        end
        return reason;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory bus between the control unit (master) and
// the memory responder (slave).
interface mem_responder_if;
    import mem_pkg::*;

    logic [ADDR_W-1:0] memAddr;
    logic              memRe;
    logic              memWe;
    logic [WORD_W-1:0] busDIn;
    logic [WORD_W-1:0] busDOut;
    logic              busDOe;
    logic              memWait;
    logic              memFault;

    modport master (
        output memAddr, memRe, memWe, busDIn,
        input  busDOut, busDOe, memWait, memFault
    );

    modport slave (
        input  memAddr, memRe, memWe, busDIn,
        output busDOut, busDOe, memWait, memFault
    );

endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH_WORDS x WORD_W storage, synchronous write, asynchronous
// read. Pure storage with no control logic; contents start at zero and are
// never touched by reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_reg [DEPTH_WORDS] = '{default: '0};

    // Commit one word per clock when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Combinational read so a zero-wait read answers in the request cycle.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-organised RAM mapped into a byte-addressed window on
// the CPU memory bus, with configurable wait states and illegal-access
// reporting.
// Optional feature macro: MEM_RO_REGION_EN -- when defined, writes to byte
// offsets below RO_LIMIT are rejected as faults.
// Bus outputs are decoded from the registered state plus the live request,
// because the zero-wait path and the first stall cycle must respond in the
// same cycle the request appears.
module mem_responder
    import mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 16'h0000,
    parameter int                DEPTH_WORDS = 256,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] RO_LIMIT    = 16'h0100
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    localparam int             IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [16:0]    WIN_SPAN  = 17'(2 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam bit             ZERO_WAIT = (WAIT_STATES == 0);
    localparam bit             ONE_WAIT  = (WAIT_STATES == 1);
`ifdef MEM_RO_REGION_EN
    localparam bit             RO_EN     = 1'b1;
`else
    localparam bit             RO_EN     = 1'b0;
`endif

    state_e            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              wr_reg;

    logic [16:0]       off17;
    logic [ADDR_W-1:0] offset;
    logic              in_window;
    logic              sel;
    logic              below_ro;
    logic [IDX_W-1:0]  idx;
    fault_e            fault_reason;
    logic              fault;
    logic              idle_go;
    logic              same_req;

    logic              arr_we;
    logic [IDX_W-1:0]  arr_addr;
    logic [WORD_W-1:0] arr_rdata;
    logic              oe;
    logic              stall;

    // The extra top bit catches addresses below ADDR_BASE (borrow).
    assign off17     = {1'b0, bus.memAddr} - {1'b0, ADDR_BASE};
    assign offset    = off17[ADDR_W-1:0];
    assign in_window = !off17[16] && (off17 < WIN_SPAN);
    assign sel       = (bus.memRe || bus.memWe) && in_window;
    assign idx       = IDX_W'(offset >> 1);
    assign below_ro  = (offset < RO_LIMIT);

    assign fault_reason = classify_fault(bus.memAddr[0], bus.memRe, bus.memWe, below_ro, RO_EN);
    assign fault        = (state_reg == IDLE) && sel && (fault_reason != FAULT_NONE);
    assign idle_go      = (state_reg == IDLE) && sel && (fault_reason == FAULT_NONE);

    // While stalled the initiator must hold address and operation unchanged.
    assign same_req = (bus.memAddr == addr_reg) && (bus.memWe == wr_reg) && (bus.memRe == !wr_reg);

    // Sequencer: latch the request on acceptance, count wait cycles, abort on a changed request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            idx_reg   <= '0;
            wr_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (idle_go && !ZERO_WAIT) begin
                        addr_reg  <= bus.memAddr;
                        idx_reg   <= idx;
                        wr_reg    <= bus.memWe;
                        cnt_reg   <= CNT_W'(1);
                        state_reg <= ONE_WAIT ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (!same_req) begin
                        state_reg <= IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    // Array port: latched index in ACCESS, live index for zero-wait access; reset drops writes.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = idx;
        if (state_reg == ACCESS) begin
            arr_addr = idx_reg;
            arr_we   = wr_reg && !rst;
        end else if (ZERO_WAIT) begin
            arr_we = idle_go && bus.memWe && !rst;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_addr),
        .wdata (bus.busDIn),
        .raddr (arr_addr),
        .rdata (arr_rdata)
    );

    // Bus output decode; everything is held low while reset is asserted.
    always_comb begin
        oe    = 1'b0;
        stall = 1'b0;
        case (state_reg)
            IDLE: begin
                oe    = ZERO_WAIT && idle_go && bus.memRe;
                stall = !ZERO_WAIT && idle_go;
            end
            WAIT: begin
                stall = same_req;
            end
            ACCESS: begin
                oe = !wr_reg;
            end
            default: begin
                oe    = 1'b0;
                stall = 1'b0;
            end
        endcase
        if (rst) begin
            oe    = 1'b0;
            stall = 1'b0;
        end
    end

    assign bus.busDOe   = oe;
    assign bus.busDOut  = oe ? arr_rdata : '0;
    assign bus.memWait  = stall;
    assign bus.memFault = fault && !rst;

endmodule
